// File: rtl/counter_xn.sv
// NUM_CH-channel down-counter timer: one-shot/periodic/PWM modes, compare, sticky flags; pulse/flag/pwm are registered (1 cycle), counter_out is a comb mux; no backpressure.
// Optional COUNTER_XN_PRESCALE_EN: CTRL[15:8] selects a per-channel tick prescale P (act on every P+1th tick).
module counter_xn #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] tick_src,
  input  logic              counter_we,
  input  logic [SEL_W-1:0]  counter_ch,
  input  logic [1:0]        counter_reg,
  input  logic [31:0]       counter_val,
  output logic [CNT_W-1:0]  counter_out,
  output logic [NUM_CH-1:0] counter_pulse,
  output logic [NUM_CH-1:0] counter_flag,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [1:0] REG_LOAD = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_CMP  = 2'd2;
  localparam logic [1:0] REG_FCLR = 2'd3;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_PWM  = 2'b11;

  logic [CNT_W-1:0]  count_q   [NUM_CH];
  logic [CNT_W-1:0]  count_d   [NUM_CH];
  logic [CNT_W-1:0]  reload_q  [NUM_CH];
  logic [CNT_W-1:0]  reload_d  [NUM_CH];
  logic [CNT_W-1:0]  compare_q [NUM_CH];
  logic [CNT_W-1:0]  compare_d [NUM_CH];
  logic [1:0]        mode_q    [NUM_CH];
  logic [1:0]        mode_d    [NUM_CH];
  logic [NUM_CH-1:0] tick_prev_q, tick_prev_d;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
`ifdef COUNTER_XN_PRESCALE_EN
  logic [7:0]        psc_q     [NUM_CH];
  logic [7:0]        psc_d     [NUM_CH];
  logic [7:0]        pre_q     [NUM_CH];
  logic [7:0]        pre_d     [NUM_CH];
`endif

  logic unused_val;
  assign unused_val = ^counter_val;

  always_comb begin
    logic tick, sel, wr_load, wr_ctrl, act, term;
    count_d     = count_q;
    reload_d    = reload_q;
    compare_d   = compare_q;
    mode_d      = mode_q;
    tick_prev_d = tick_src;
    pulse_d     = '0;
    flag_d      = flag_q;
    pwm_d       = '0;
`ifdef COUNTER_XN_PRESCALE_EN
    psc_d       = psc_q;
    pre_d       = pre_q;
`endif
    if (counter_we && counter_reg == REG_FCLR) begin
      flag_d = flag_q & ~counter_val[NUM_CH-1:0];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      tick    = tick_src[i] & ~tick_prev_q[i];
      sel     = counter_we && (counter_ch == SEL_W'(i));
      wr_load = sel && (counter_reg == REG_LOAD);
      wr_ctrl = sel && (counter_reg == REG_CTRL);
      act     = 1'b0;
      term    = 1'b0;
      pwm_d[i] = (mode_q[i] == MODE_PWM) && (count_q[i] < compare_q[i]);
      // LOAD/CTRL writes take priority and swallow a coincident tick.
      if (wr_load) begin
        reload_d[i] = counter_val[CNT_W-1:0];
        count_d[i]  = counter_val[CNT_W-1:0];
`ifdef COUNTER_XN_PRESCALE_EN
        pre_d[i]    = 8'd0;
`endif
      end else if (wr_ctrl) begin
        mode_d[i] = counter_val[1:0];
`ifdef COUNTER_XN_PRESCALE_EN
        psc_d[i]  = counter_val[15:8];
        pre_d[i]  = 8'd0;
`endif
      end else if (tick && mode_q[i] != MODE_STOP) begin
`ifdef COUNTER_XN_PRESCALE_EN
        act      = (pre_q[i] == psc_q[i]);
        pre_d[i] = act ? 8'd0 : pre_q[i] + 8'd1;
`else
        act = 1'b1;
`endif
      end
      if (act) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - 1'b1;
        end else begin
          term = 1'b1;
          if (mode_q[i] == MODE_ONE) begin
            mode_d[i] = MODE_STOP;
          end else begin
            count_d[i] = reload_q[i];
          end
        end
      end
      if (sel && counter_reg == REG_CMP) begin
        compare_d[i] = counter_val[CNT_W-1:0];
      end
      pulse_d[i] = term;
      if (term) begin
        flag_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]   <= '0;
        reload_q[i]  <= '0;
        compare_q[i] <= '0;
        mode_q[i]    <= MODE_STOP;
`ifdef COUNTER_XN_PRESCALE_EN
        psc_q[i]     <= 8'd0;
        pre_q[i]     <= 8'd0;
`endif
      end
      tick_prev_q <= '0;
      flag_q      <= '0;
      pulse_q     <= '0;
      pwm_q       <= '0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      compare_q   <= compare_d;
      mode_q      <= mode_d;
`ifdef COUNTER_XN_PRESCALE_EN
      psc_q       <= psc_d;
      pre_q       <= pre_d;
`endif
      tick_prev_q <= tick_prev_d;
      flag_q      <= flag_d;
      pulse_q     <= pulse_d;
      pwm_q       <= pwm_d;
    end
  end

  assign counter_out   = count_q[counter_ch];
  assign counter_pulse = pulse_q;
  assign counter_flag  = flag_q;
  assign pwm_out       = pwm_q;

endmodule

// File: tb/tb_counter_xn.sv
// Directed bench for counter_xn: per-cycle comparison against a behavioural timer model plus literal spot checks.
module tb_counter_xn;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] tick_src = '0;
  logic              counter_we = 1'b0;
  logic [SEL_W-1:0]  counter_ch = '0;
  logic [1:0]        counter_reg = '0;
  logic [31:0]       counter_val = '0;
  logic [CNT_W-1:0]  counter_out;
  logic [NUM_CH-1:0] counter_pulse, counter_flag, pwm_out;

  int checks = 0;
  int errors = 0;

  counter_xn #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .tick_src(tick_src), .counter_we(counter_we),
    .counter_ch(counter_ch), .counter_reg(counter_reg), .counter_val(counter_val),
    .counter_out(counter_out), .counter_pulse(counter_pulse),
    .counter_flag(counter_flag), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Behavioural timer model: plain integer per-channel state.
  int m_count [NUM_CH];
  int m_reload[NUM_CH];
  int m_cmp   [NUM_CH];
  int m_mode  [NUM_CH];
  int m_psc   [NUM_CH];
  int m_pre   [NUM_CH];
  bit m_prev  [NUM_CH];
  bit m_flag  [NUM_CH];
  bit m_pulse [NUM_CH];
  bit m_pwm   [NUM_CH];
  bit started = 0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_count[i] = 0; m_reload[i] = 0; m_cmp[i] = 0; m_mode[i] = 0;
        m_psc[i] = 0; m_pre[i] = 0; m_prev[i] = 0; m_flag[i] = 0;
        m_pulse[i] = 0; m_pwm[i] = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit edge_seen, hit, fire;
        m_pwm[i]   = (m_mode[i] == 3) && (m_count[i] < m_cmp[i]);
        m_pulse[i] = 0;
        edge_seen  = tick_src[i] && !m_prev[i];
        hit        = counter_we && (int'(counter_ch) == i);
        fire       = 0;
        if (counter_we && counter_reg == 3 && counter_val[i]) m_flag[i] = 0;
        if (hit && counter_reg == 0) begin
          m_reload[i] = int'(counter_val); m_count[i] = int'(counter_val); m_pre[i] = 0;
        end else if (hit && counter_reg == 1) begin
          m_mode[i] = int'(counter_val[1:0]);
`ifdef COUNTER_XN_PRESCALE_EN
          m_psc[i] = int'(counter_val[15:8]);
`endif
          m_pre[i] = 0;
        end else if (edge_seen && m_mode[i] != 0) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] > m_psc[i]) begin
            m_pre[i] = 0;
            fire = 1;
          end
        end
        if (fire) begin
          if (m_count[i] > 0) m_count[i] = m_count[i] - 1;
          else begin
            m_pulse[i] = 1;
            m_flag[i]  = 1;
            if (m_mode[i] == 1) m_mode[i] = 0;
            else m_count[i] = m_reload[i];
          end
        end
        if (hit && counter_reg == 2) m_cmp[i] = int'(counter_val);
        m_prev[i] = tick_src[i];
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [NUM_CH-1:0] ep, ef, ew;
      for (int i = 0; i < NUM_CH; i++) begin
        ep[i] = m_pulse[i]; ef[i] = m_flag[i]; ew[i] = m_pwm[i];
      end
      check("model_count", longint'(counter_out), longint'(m_count[counter_ch]));
      check("model_pulse", longint'(counter_pulse), longint'(ep));
      check("model_flag",  longint'(counter_flag),  longint'(ef));
      check("model_pwm",   longint'(pwm_out),       longint'(ew));
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wr(input int ch, input int r, input int v);
    counter_we = 1'b1; counter_ch = SEL_W'(ch); counter_reg = 2'(r); counter_val = 32'(v);
    step();
    counter_we = 1'b0;
  endtask

  // One tick: one cycle high then one cycle low. Returns pulse seen after the edge.
  task automatic tick(input int ch, output bit pulse_seen);
    tick_src[ch] = 1'b1;
    step();
    pulse_seen = counter_pulse[ch];
    tick_src[ch] = 1'b0;
    step();
  endtask

  initial begin
    int exp2[8] = '{4, 3, 2, 1, 0, 0, 0, 0};
    int npulse, nhigh;
    bit p;

    // 1. reset with ticks toggling
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick_src = ~tick_src;
      step();
    end
    rst = 1'b0;
    tick_src = '0;
    check("rst_out",   longint'(counter_out),   0);
    check("rst_pulse", longint'(counter_pulse), 0);
    check("rst_flag",  longint'(counter_flag),  0);
    check("rst_pwm",   longint'(pwm_out),       0);
    for (int k = 0; k < 3; k++) tick(0, p);
    check("rst_nodec", longint'(counter_out), 0);

    // 2. one-shot on ch1
    wr(1, 0, 5);
    check("os_load", longint'(counter_out), 5);
    wr(1, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(1, p);
      check($sformatf("os_cnt%0d", k), longint'(counter_out), exp2[k-1]);
      check($sformatf("os_pls%0d", k), longint'(p), (k == 6) ? 1 : 0);
    end
    check("os_flag", longint'(counter_flag[1]), 1);

    // 3. periodic on ch0
    counter_ch = 2'd0;
    wr(0, 0, 3);
    wr(0, 1, 2);
    npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(0, p);
      if (p) begin
        npulse++;
        check("per_pos", longint'(k % 4), 0);
      end
    end
    check("per_npulse", longint'(npulse), 3);
    check("per_flag", longint'(counter_flag[0]), 1);
    wr(0, 3, 1);
    check("per_fclr", longint'(counter_flag[0]), 0);

    // 4. PWM on ch2
    counter_ch = 2'd2;
    wr(2, 0, 9);
    wr(2, 2, 3);
    wr(2, 1, 3);
    nhigh = 0;
    for (int k = 0; k < 10; k++) begin tick(2, p); nhigh += int'(pwm_out[2]); end
    check("pwm_duty3", longint'(nhigh), 3);
    wr(2, 2, 0);
    nhigh = 0;
    for (int k = 0; k < 10; k++) begin tick(2, p); nhigh += int'(pwm_out[2]); end
    check("pwm_cmp0", longint'(nhigh), 0);
    wr(2, 2, 12);
    nhigh = 0;
    for (int k = 0; k < 10; k++) begin tick(2, p); nhigh += int'(pwm_out[2]); end
    check("pwm_cmp12", longint'(nhigh), 10);

    // 5a. LOAD colliding with a tick on ch3
    counter_ch = 2'd3;
    wr(3, 0, 6);
    wr(3, 1, 2);
    tick(3, p);
    tick(3, p);
    check("col_pre", longint'(counter_out), 4);
    tick_src[3] = 1'b1;
    wr(3, 0, 7);
    check("col_load", longint'(counter_out), 7);
    check("col_nopls", longint'(counter_pulse[3]), 0);
    tick_src[3] = 1'b0;
    step();
    check("col_hold", longint'(counter_out), 7);

    // 5b. FLAG_CLR in the terminal cycle of ch0 (count is 3 after 12 ticks)
    counter_ch = 2'd0;
    for (int k = 0; k < 3; k++) tick(0, p);
    check("fc_zero", longint'(counter_out), 0);
    tick_src[0] = 1'b1;
    wr(0, 3, 1);
    check("fc_pulse", longint'(counter_pulse[0]), 1);
    check("fc_flag", longint'(counter_flag[0]), 1);
    tick_src[0] = 1'b0;
    step();

    // 6. prescale P=2, periodic, reload 1 on ch1
    counter_ch = 2'd1;
    wr(1, 0, 1);
    wr(1, 1, 32'h0202);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin tick(1, p); npulse += int'(p); end
`ifdef COUNTER_XN_PRESCALE_EN
    check("psc_npulse", longint'(npulse), 2);
`else
    check("psc_npulse", longint'(npulse), 6);
`endif

    // mid-operation reset
    tick_src[0] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick_src = '0;
    check("mrst_flag", longint'(counter_flag), 0);
    check("mrst_pwm",  longint'(pwm_out), 0);
    check("mrst_out",  longint'(counter_out), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
